// File: rtl/counter_poll_ctrl_if.sv
// Request/response bus between the poll sequencer (master) and the per-FIFO counter block (slave).
interface counter_poll_ctrl_if #(
    parameter int IDX_W = 2,
    parameter int CNT_W = 5
);
    logic             req;
    logic [IDX_W-1:0] idx;
    logic             valid_in;
    logic [CNT_W-1:0] data_in;

    modport master (output req, output idx, input valid_in, input data_in);
    modport slave  (input req, input idx, output valid_in, output data_in);
endinterface

// File: rtl/counter_poll_ctrl.sv
// Sweeps every FIFO counter in turn, captures the counts into a shadow set and commits
// them atomically to counts_out; a RESET on the link state bus cancels the sweep.
module counter_poll_ctrl #(
    parameter int         NUM_FIFOS = 4,
    parameter int         CNT_W     = 5,
    parameter int         IDX_W     = 2,
    parameter logic [3:0] ST_RESET  = 4'b0001,
    parameter logic [3:0] ST_IDLE   = 4'b0100
) (
    input  logic                       clk,
    input  logic                       reset_L,
    input  logic [3:0]                 state,
    input  logic                       start,
    counter_poll_ctrl_if.master        cnt,
    output logic                       busy,
    output logic                       done,
    output logic                       aborted,
    output logic [NUM_FIFOS*CNT_W-1:0] counts_out
);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_FIFOS - 1);

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        POLL   = 2'd1,
        COMMIT = 2'd2
    } fsm_t;

    fsm_t                       fsm_q, fsm_d;
    logic [PTR_W-1:0]           ptr_q, ptr_d;
    logic                       req_q, req_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       aborted_q, aborted_d;
    logic [NUM_FIFOS*CNT_W-1:0] counts_q, counts_d;
    logic [NUM_FIFOS*CNT_W-1:0] shadow_q, shadow_d;
    logic                       accept_s;

    // The counter block only answers in IDLE, so a valid outside IDLE is not trusted.
    assign accept_s = cnt.valid_in && (state == ST_IDLE);

    // Next-state and output decode for the sweep sequencer.
    always_comb begin
        fsm_d     = fsm_q;
        ptr_d     = ptr_q;
        req_d     = req_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        counts_d  = counts_q;
        shadow_d  = shadow_q;
        case (fsm_q)
            // The commit itself happens on the edge that leaves POLL, so COMMIT is already
            // idle and may launch the next sweep in the cycle done is high.
            WAIT, COMMIT: begin
                if (start && (state != ST_RESET)) begin
                    fsm_d  = POLL;
                    ptr_d  = {PTR_W{1'b0}};
                    req_d  = 1'b1;
                    idx_d  = {IDX_W{1'b0}};
                    busy_d = 1'b1;
                end else begin
                    fsm_d  = WAIT;
                end
            end
            POLL: begin
                if (state == ST_RESET) begin
                    fsm_d     = WAIT;
                    req_d     = 1'b0;
                    idx_d     = {IDX_W{1'b0}};
                    busy_d    = 1'b0;
                    aborted_d = 1'b1;
                end else if (accept_s) begin
                    for (int i = 0; i < NUM_FIFOS; i++) begin
                        if (ptr_q == PTR_W'(i)) begin
                            shadow_d[i*CNT_W +: CNT_W] = cnt.data_in;
                        end else begin
                            shadow_d[i*CNT_W +: CNT_W] = shadow_q[i*CNT_W +: CNT_W];
                        end
                    end
                    if (ptr_q == LAST_PTR) begin
                        fsm_d    = COMMIT;
                        req_d    = 1'b0;
                        idx_d    = {IDX_W{1'b0}};
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        counts_d = shadow_d;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                        idx_d = IDX_W'(ptr_q + PTR_W'(1));
                    end
                end else begin
                    fsm_d = POLL;
                end
            end
            default: begin
                fsm_d  = WAIT;
                req_d  = 1'b0;
                idx_d  = {IDX_W{1'b0}};
                busy_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            fsm_q     <= WAIT;
            ptr_q     <= {PTR_W{1'b0}};
            req_q     <= 1'b0;
            idx_q     <= {IDX_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            counts_q  <= {(NUM_FIFOS*CNT_W){1'b0}};
            shadow_q  <= {(NUM_FIFOS*CNT_W){1'b0}};
        end else begin
            fsm_q     <= fsm_d;
            ptr_q     <= ptr_d;
            req_q     <= req_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            counts_q  <= counts_d;
            shadow_q  <= shadow_d;
        end
    end

    assign cnt.req    = req_q;
    assign cnt.idx    = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign counts_out = counts_q;
endmodule

// File: tb/tb_counter_poll_ctrl.sv
// Randomized bench for counter_poll_ctrl against a sweep-level reference model.
module tb_counter_poll_ctrl;
    localparam int N = 4;
    localparam int CW = 5;
    localparam logic [3:0] ST_RESET = 4'b0001;
    localparam logic [3:0] ST_IDLE  = 4'b0100;
    localparam logic [3:0] ST_OTHER = 4'b1000;

    logic            clk = 1'b0;
    logic            reset_L;
    logic [3:0]      state;
    logic            start;
    logic            busy, done, aborted;
    logic [N*CW-1:0] counts_out;
    logic [CW-1:0]   cnt_mem [N];

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    // Reference model: a sweep is "active at position pos"; counts are plain ints.
    bit m_active, m_done, m_abort;
    int m_pos;
    int m_snap [N];
    int m_counts [N];

    counter_poll_ctrl_if #(.IDX_W(2), .CNT_W(CW)) cif ();

    assign cif.valid_in = cif.req && (state == ST_IDLE);
    assign cif.data_in  = cnt_mem[cif.idx];

    counter_poll_ctrl dut (
        .clk(clk), .reset_L(reset_L), .state(state), .start(start), .cnt(cif),
        .busy(busy), .done(done), .aborted(aborted), .counts_out(counts_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N*CW-1:0] pack_counts();
        logic [N*CW-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i*CW +: CW] = CW'(m_counts[i]);
        return v;
    endfunction

    always @(posedge clk) begin
        m_done  = 1'b0;
        m_abort = 1'b0;
        if (!reset_L) begin
            m_active = 1'b0;
            m_pos    = 0;
            for (int i = 0; i < N; i++) m_counts[i] = 0;
        end else if (!m_active) begin
            if (start && state != ST_RESET) begin
                m_active = 1'b1;
                m_pos    = 0;
            end
        end else if (state == ST_RESET) begin
            m_active = 1'b0;
            m_abort  = 1'b1;
        end else if (state == ST_IDLE) begin
            m_snap[m_pos] = int'(cnt_mem[m_pos]);
            if (m_pos == N - 1) begin
                for (int i = 0; i < N; i++) m_counts[i] = m_snap[i];
                m_done   = 1'b1;
                m_active = 1'b0;
            end else begin
                m_pos++;
            end
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_active));
            chk("req", 32'(cif.req), 32'(m_active));
            chk("idx", 32'(cif.idx), m_active ? m_pos : 0);
            chk("done", 32'(done), 32'(m_done));
            chk("aborted", 32'(aborted), 32'(m_abort));
            chk("counts_out", 32'(counts_out), 32'(pack_counts()));
            chk("done_with_aborted", 32'(done & aborted), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input logic [1:0] target);
        int t = 0;
        while (cif.idx !== target && t < 20) begin
            step();
            t++;
        end
        chk("wait_idx_timeout", 32'(cif.idx), 32'(target));
    endtask

    initial begin
        int done_cyc, n_done;
        logic [N*CW-1:0] exp_pack;

        reset_L = 1'b0; start = 1'b1; state = ST_IDLE;
        for (int i = 0; i < N; i++) cnt_mem[i] = '0;
        // 1: reset with start asserted
        step(); step();
        chk("reset_counts", 32'(counts_out), 32'h0);
        chk("reset_req", 32'(cif.req), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        reset_L = 1'b1; start = 1'b0;
        step();

        // 2: nominal sweep {3,7,0,31}
        cnt_mem[0] = 5'd3; cnt_mem[1] = 5'd7; cnt_mem[2] = 5'd0; cnt_mem[3] = 5'd31;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("nom_req_c1", 32'({cif.req, cif.idx}), 32'({1'b1, 2'd0}));
        done_cyc = 0;
        for (int k = 1; k <= 10; k++) begin
            if (done && done_cyc == 0) done_cyc = k;
            step();
        end
        chk("nom_done_cycle", 32'(done_cyc), 32'd5);
        chk("nom_counts", 32'(counts_out), 32'hF80E3);

        // 4: abort at idx 1
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idx(2'd1);
        state = ST_RESET;
        step();
        state = ST_IDLE;
        chk("abort_pulse", 32'(aborted), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_req", 32'(cif.req), 32'd0);
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            if (done) n_done++;
            step();
        end
        chk("abort_no_done", 32'(n_done), 32'd0);
        chk("abort_counts_kept", 32'(counts_out), 32'hF80E3);

        // 3: stall at idx 2 for three cycles
        for (int i = 0; i < N; i++) cnt_mem[i] = CW'($urandom);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idx(2'd2);
        state = ST_OTHER;
        step(); step(); step();
        chk("stall_hold", 32'({cif.req, cif.idx}), 32'({1'b1, 2'd2}));
        state = ST_IDLE;
        done_cyc = 0;
        for (int k = 6; k <= 12; k++) begin
            if (done && done_cyc == 0) done_cyc = k;
            step();
        end
        chk("stall_done_cycle", 32'(done_cyc), 32'd8);
        exp_pack = {cnt_mem[3], cnt_mem[2], cnt_mem[1], cnt_mem[0]};
        chk("stall_counts", 32'(counts_out), 32'(exp_pack));

        // 5: start held high
        start = 1'b1;
        step();
        n_done = 0;
        for (int k = 1; k <= 30; k++) begin
            if (done) n_done++;
            step();
        end
        start = 1'b0;
        chk("b2b_done_count", 32'(n_done), 32'd6);
        for (int k = 0; k < 6; k++) step();

        // 6: reset mid-poll
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        reset_L = 1'b0;
        step();
        chk("midreset_all", 32'({busy, done, aborted, cif.req, cif.idx}), 32'd0);
        chk("midreset_counts", 32'(counts_out), 32'h0);
        reset_L = 1'b1;
        step();

        // random phase
        for (int k = 0; k < 1500; k++) begin
            int r = $urandom_range(0, 99);
            state   = (r < 80) ? ST_IDLE : (r < 92) ? ST_OTHER : ST_RESET;
            start   = ($urandom_range(0, 3) == 0);
            reset_L = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 7) == 0) cnt_mem[$urandom_range(0, N-1)] = CW'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
